// File: rtl/g11620_pix_capture_if.sv
// Pixel output stream of the line capture block: data, valid, ready and
// end-of-line marker, seen from the producer (master) and consumer (slave).
interface g11620_pix_capture_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/g11620_pix_capture.sv
// Line capture with a ping-pong pair of line banks: the ADC side fills one
// bank while the stream side drains the other, dropping lines when both are full.
module g11620_pix_capture #(
    parameter int unsigned PIX_NUM = 511,
    parameter int          DATA_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_reset_in,
    input  logic                 ad_sp,
    input  logic                 adc_valid,
    input  logic [DATA_W-1:0]    adc_data,
    g11620_pix_capture_if.master m_axis,
    output logic                 line_done_o,
    output logic                 overflow_o,
    output logic [15:0]          line_cnt_o
);
    localparam int IDX_W = (PIX_NUM > 0) ? $clog2(PIX_NUM + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_NUM);

    typedef enum logic [1:0] {W_IDLE, W_CAPTURE, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_t;

    logic [DATA_W-1:0] mem [0:(2 << IDX_W)-1];

    logic             clr;
    w_state_t         w_state;
    logic             w_bank;
    logic [IDX_W-1:0] w_idx;
    r_state_t         r_state;
    logic             r_bank;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       bank_full;
    logic             wr_en;
    logic             commit;
    logic             release_bank;
    logic             rd_en_p0;
    logic [IDX_W-1:0] rd_idx_p0;
    logic [DATA_W-1:0] pix_p1;
    logic             vld_p1;
    logic             last_p1;
    logic             line_done_r;
    logic             overflow_r;
    logic [15:0]      line_cnt_r;

    assign clr          = !rst_n || soft_reset_in;
    assign wr_en        = !clr && (w_state == W_CAPTURE) && adc_valid;
    assign commit       = wr_en && (w_idx == LAST_IDX);
    assign release_bank = (r_state == R_STREAM) && vld_p1 && m_axis.m_tready
                          && (r_idx == LAST_IDX);

    // Write side: the sample arriving with ad_sp is not part of the line.
    always_ff @(posedge clk) begin
        if (clr) begin
            w_state     <= W_IDLE;
            w_bank      <= 1'b0;
            w_idx       <= '0;
            line_done_r <= 1'b0;
            overflow_r  <= 1'b0;
            if (!rst_n) begin
                line_cnt_r <= 16'd0;
            end
        end else begin
            line_done_r <= 1'b0;
            overflow_r  <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (ad_sp) begin
                        w_idx <= '0;
                        if (!bank_full[w_bank]) begin
                            w_state <= W_CAPTURE;
                        end else begin
                            w_state    <= W_DROP;
                            overflow_r <= 1'b1;
                        end
                    end
                end
                W_CAPTURE: begin
                    if (adc_valid) begin
                        if (w_idx == LAST_IDX) begin
                            w_idx       <= '0;
                            w_bank      <= ~w_bank;
                            line_done_r <= 1'b1;
                            line_cnt_r  <= line_cnt_r + 16'd1;
                            w_state     <= W_IDLE;
                        end else begin
                            w_idx <= w_idx + IDX_W'(1);
                        end
                    end
                end
                W_DROP: begin
                    if (adc_valid) begin
                        if (w_idx == LAST_IDX) begin
                            w_idx   <= '0;
                            w_state <= W_IDLE;
                        end else begin
                            w_idx <= w_idx + IDX_W'(1);
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{w_bank, w_idx}] <= adc_data;
        end
    end

    // Commit and release never target the same bank, so each flag has one owner per cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            bank_full <= 2'b00;
        end else begin
            if (commit && !w_bank) begin
                bank_full[0] <= 1'b1;
            end else if (release_bank && !r_bank) begin
                bank_full[0] <= 1'b0;
            end
            if (commit && w_bank) begin
                bank_full[1] <= 1'b1;
            end else if (release_bank && r_bank) begin
                bank_full[1] <= 1'b0;
            end
        end
    end

    // Stage p0: read address, prefetching the next pixel on every accepted beat.
    always_comb begin
        rd_en_p0  = 1'b0;
        rd_idx_p0 = '0;
        if (r_state == R_FETCH) begin
            rd_en_p0 = 1'b1;
        end else if ((r_state == R_STREAM) && m_axis.m_tready && (r_idx != LAST_IDX)) begin
            rd_en_p0  = 1'b1;
            rd_idx_p0 = r_idx + IDX_W'(1);
        end
    end

    // Stage p1: RAM output register doubles as the stream data register.
    always_ff @(posedge clk) begin
        if (clr) begin
            pix_p1 <= '0;
        end else if (rd_en_p0) begin
            pix_p1 <= mem[{r_bank, rd_idx_p0}];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= R_IDLE;
            r_bank  <= 1'b0;
            r_idx   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bank_full[r_bank]) begin
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_idx   <= '0;
                    vld_p1  <= 1'b1;
                    last_p1 <= (LAST_IDX == '0);
                    r_state <= R_STREAM;
                end
                R_STREAM: begin
                    if (m_axis.m_tready) begin
                        if (r_idx == LAST_IDX) begin
                            vld_p1  <= 1'b0;
                            last_p1 <= 1'b0;
                            r_idx   <= '0;
                            r_bank  <= ~r_bank;
                            r_state <= bank_full[~r_bank] ? R_FETCH : R_IDLE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            last_p1 <= ((r_idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign m_axis.m_tdata  = pix_p1;
    assign m_axis.m_tvalid = vld_p1;
    assign m_axis.m_tlast  = last_p1;
    assign line_done_o     = line_done_r;
    assign overflow_o      = overflow_r;
    assign line_cnt_o      = line_cnt_r;
endmodule

// File: tb/tb_g11620_pix_capture.sv
// Directed bench for g11620_pix_capture: captured pixels go into a scoreboard
// queue and are matched against every accepted stream beat.
module tb_g11620_pix_capture;
    localparam int PIX_NUM = 511;
    localparam int DATA_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              soft_reset_in = 1'b0;
    logic              ad_sp = 1'b0;
    logic              adc_valid = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              line_done_o;
    logic              overflow_o;
    logic [15:0]       line_cnt_o;

    g11620_pix_capture_if #(.DATA_W(DATA_W)) axis ();

    g11620_pix_capture #(.PIX_NUM(PIX_NUM), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_reset_in(soft_reset_in),
        .ad_sp        (ad_sp),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .m_axis       (axis),
        .line_done_o  (line_done_o),
        .overflow_o   (overflow_o),
        .line_cnt_o   (line_cnt_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 0;
    int          beats = 0;
    int          lasts = 0;
    int          ld_cnt = 0;
    int          ov_cnt = 0;
    logic [15:0] exp_lines = 16'd0;
    logic [DATA_W:0] q[$];
    logic        stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data;
    logic        stall_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       axis.m_tready = 1'b0;
            1:       axis.m_tready = 1'b1;
            default: axis.m_tready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    // Stream monitor: scoreboard pop on handshake, stability check across stalls.
    always @(negedge clk) begin
        if (rst_n && !soft_reset_in) begin
            if (stall_prev) begin
                chk("stall_tvalid", axis.m_tvalid, 1);
                chk("stall_tdata", axis.m_tdata, stall_data);
                chk("stall_tlast", axis.m_tlast, stall_last);
            end
            if (axis.m_tvalid && axis.m_tready) begin
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    logic [DATA_W:0] e;
                    e = q.pop_front();
                    chk("beat_tdata", axis.m_tdata, e[DATA_W-1:0]);
                    chk("beat_tlast", axis.m_tlast, e[DATA_W]);
                end
                beats++;
                if (axis.m_tlast) lasts++;
            end
            stall_prev = axis.m_tvalid && !axis.m_tready;
            stall_data = axis.m_tdata;
            stall_last = axis.m_tlast;
        end else begin
            stall_prev = 1'b0;
        end
        if (line_done_o) ld_cnt++;
        if (overflow_o) ov_cnt++;
    end

    task automatic send_line(input logic [15:0] base, input bit toggle, input bit commit,
                             input int sp_at);
        ad_sp = 1'b1;
        tick();
        ad_sp = 1'b0;
        chk("overflow_o_on_start", overflow_o, !commit);
        for (int i = 0; i <= PIX_NUM; i++) begin
            if (toggle) begin
                adc_valid = 1'b0;
                tick();
            end
            adc_valid = 1'b1;
            adc_data  = base + 16'(i);
            ad_sp     = (i == sp_at);
            if (commit) q.push_back({(i == PIX_NUM), base + 16'(i)});
            tick();
            ad_sp = 1'b0;
        end
        adc_valid = 1'b0;
        chk("line_done_o_after_last", line_done_o, commit);
        if (commit) exp_lines++;
        chk("line_cnt_o", line_cnt_o, exp_lines);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || axis.m_tvalid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_complete", (q.size() == 0) && !axis.m_tvalid, 1);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats < target && n < budget) begin
            tick();
            n++;
        end
        chk("beats_reached", beats >= target, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        axis.m_tready = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", axis.m_tvalid, 0);
        chk("rst_tlast", axis.m_tlast, 0);
        chk("rst_tdata", axis.m_tdata, 0);
        chk("rst_line_done", line_done_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_line_cnt", line_cnt_o, 0);
        rst_n = 1'b1;
        tick();
        ld_cnt = 0; ov_cnt = 0;

        // Single line, free-flowing stream
        rdy_mode = 1; beats = 0; lasts = 0;
        send_line(16'd0, 1'b0, 1'b1, -1);
        drain(2000);
        chk("l1_beats", beats, 512);
        chk("l1_lasts", lasts, 1);
        chk("l1_line_done_pulses", ld_cnt, 1);

        // adc_valid toggling every other cycle
        beats = 0; lasts = 0;
        send_line(16'd1000, 1'b1, 1'b1, -1);
        drain(2000);
        chk("tog_beats", beats, 512);
        chk("tog_line_done_pulses", ld_cnt, 2);

        // Downstream blocked: two lines fill the banks, the third is dropped
        rdy_mode = 0; beats = 0; lasts = 0;
        send_line(16'd2000, 1'b0, 1'b1, -1);
        send_line(16'd3000, 1'b0, 1'b1, -1);
        send_line(16'd4000, 1'b0, 1'b0, -1);
        tick();
        chk("ovf_pulses", ov_cnt, 1);
        chk("ovf_line_cnt", line_cnt_o, 4);
        chk("ovf_held_tvalid", axis.m_tvalid, 1);
        chk("ovf_held_tdata", axis.m_tdata, 2000);
        rdy_mode = 1;
        drain(3000);
        chk("ovf_beats", beats, 1024);
        chk("ovf_lasts", lasts, 2);

        // Random backpressure with a second line captured during the stream
        rdy_mode = 2; beats = 0;
        send_line(16'd5000, 1'b0, 1'b1, -1);
        send_line(16'd5600, 1'b0, 1'b1, -1);
        drain(5000);
        chk("rnd_beats", beats, 1024);

        // ad_sp repeated mid-line is ignored
        rdy_mode = 1; beats = 0;
        send_line(16'd7000, 1'b0, 1'b1, 300);
        drain(2000);
        chk("sp_beats", beats, 512);

        // Soft reset part-way through a capture
        ad_sp = 1'b1;
        tick();
        ad_sp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'hA000 + 16'(i);
            tick();
        end
        adc_valid = 1'b0;
        soft_reset_in = 1'b1;
        tick();
        soft_reset_in = 1'b0;
        chk("softcap_tvalid", axis.m_tvalid, 0);
        chk("softcap_line_cnt", line_cnt_o, exp_lines);
        beats = 0;
        send_line(16'd8000, 1'b0, 1'b1, -1);
        drain(2000);
        chk("softcap_beats", beats, 512);

        // Soft reset part-way through a stream
        beats = 0;
        send_line(16'd9000, 1'b0, 1'b1, -1);
        wait_beats(100, 1000);
        soft_reset_in = 1'b1;
        tick();
        soft_reset_in = 1'b0;
        chk("softstr_tvalid", axis.m_tvalid, 0);
        chk("softstr_line_cnt", line_cnt_o, exp_lines);
        q.delete();
        repeat (3) tick();
        chk("softstr_idle", axis.m_tvalid, 0);
        beats = 0;
        send_line(16'd9500, 1'b0, 1'b1, -1);
        drain(2000);
        chk("softstr_beats", beats, 512);

        // Hard reset part-way through a stream under backpressure
        rdy_mode = 2; beats = 0;
        send_line(16'd12000, 1'b0, 1'b1, -1);
        wait_beats(50, 1000);
        rst_n = 1'b0;
        tick();
        chk("hard_tvalid", axis.m_tvalid, 0);
        chk("hard_tdata", axis.m_tdata, 0);
        chk("hard_line_cnt", line_cnt_o, 0);
        rst_n = 1'b1;
        q.delete();
        exp_lines = 16'd0;
        repeat (3) tick();
        chk("hard_idle", axis.m_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
